// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared state type and constants for the SCCB responder
package sccb_pkg;

  localparam int         SCCB_BITS      = 8;
  localparam logic [7:0] DEV_ID_DEFAULT = 8'h42;
  localparam int         REG_DEPTH      = 256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_NA,
    ST_IGNORE
  } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// rtl/sccb_line_sync.sv - SIOC/SIOD synchronizers and registered START/STOP/edge events
module sccb_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sioc_i,
  input  logic siod_i,
  output logic sioc_rise_o,
  output logic sioc_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic siod_o
);

  logic sioc_s1_q, sioc_s2_q, sioc_p_q;
  logic siod_s1_q, siod_s2_q, siod_p_q;
  logic rise_q, fall_q, start_q, stop_q, siod_q;

  // Idle bus level is high, so resetting to 1 avoids spurious events after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sioc_s1_q <= 1'b1;
      sioc_s2_q <= 1'b1;
      sioc_p_q  <= 1'b1;
      siod_s1_q <= 1'b1;
      siod_s2_q <= 1'b1;
      siod_p_q  <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      siod_q    <= 1'b1;
    end else begin
      sioc_s1_q <= sioc_i;
      sioc_s2_q <= sioc_s1_q;
      sioc_p_q  <= sioc_s2_q;
      siod_s1_q <= siod_i;
      siod_s2_q <= siod_s1_q;
      siod_p_q  <= siod_s2_q;
      rise_q    <= sioc_s2_q & ~sioc_p_q;
      fall_q    <= ~sioc_s2_q & sioc_p_q;
      start_q   <= sioc_s2_q & sioc_p_q & ~siod_s2_q & siod_p_q;
      stop_q    <= sioc_s2_q & sioc_p_q & siod_s2_q & ~siod_p_q;
      siod_q    <= siod_s2_q;
    end
  end

  assign sioc_rise_o = rise_q;
  assign sioc_fall_o = fall_q;
  assign start_o     = start_q;
  assign stop_o      = stop_q;
  assign siod_o      = siod_q;

endmodule

// File: rtl/sccb_responder.sv
// rtl/sccb_responder.sv - SCCB slave emulator with 256x8 register file; SCCB_RESP_ACK_EN drives ACK bits low
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID = DEV_ID_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sioc_i,
  inout  wire        siod_io,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_valid,
  output logic       busy,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data
);

  localparam logic [2:0] LAST_BIT = 3'(SCCB_BITS - 1);
`ifdef SCCB_RESP_ACK_EN
  localparam logic ACK_DRIVE = 1'b1;
`else
  localparam logic ACK_DRIVE = 1'b0;
`endif

  logic ev_rise, ev_fall, ev_start, ev_stop, sda;

  sccb_line_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .sioc_i      (sioc_i),
    .siod_i      (siod_io),
    .sioc_rise_o (ev_rise),
    .sioc_fall_o (ev_fall),
    .start_o     (ev_start),
    .stop_o      (ev_stop),
    .siod_o      (sda)
  );

  sccb_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  cur_addr_q, cur_addr_d;
  logic        oe_q, oe_d;
  logic        bit9_q, bit9_d;
  logic        rnw_q, rnw_d;
  logic        na_q, na_d;
  logic        busy_q, busy_d;
  logic        wr_valid_q, wr_valid_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  reg_q [REG_DEPTH];
  logic        reg_we;
  logic [7:0]  rx_byte, addr_inc, rd_cur, rd_nxt;

  assign addr_inc = cur_addr_q + 8'd1;
  assign rd_cur   = reg_q[cur_addr_q];
  assign rd_nxt   = reg_q[addr_inc];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    cur_addr_d = cur_addr_q;
    oe_d       = oe_q;
    bit9_d     = bit9_q;
    rnw_d      = rnw_q;
    na_d       = na_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    rd_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;
    rx_byte    = {shift_q[6:0], sda};

    if (ev_start) begin
      state_d   = ST_ID;
      bit_cnt_d = '0;
      bit9_d    = 1'b0;
      oe_d      = 1'b0;
      busy_d    = 1'b1;
    end else if (ev_stop) begin
      state_d = ST_IDLE;
      bit9_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ID, ST_ADDR, ST_WDATA: begin
          if (ev_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              bit9_d = 1'b0;
              if (state_q == ST_ID) begin
                if (rx_byte[7:1] != DEV_ID[7:1]) begin
                  state_d = ST_IGNORE;
                end else begin
                  rnw_d   = rx_byte[0];
                  state_d = ST_ID_ACK;
                end
              end else if (state_q == ST_ADDR) begin
                cur_addr_d = rx_byte;
                state_d    = ST_ADDR_ACK;
              end else begin
                reg_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = cur_addr_q;
                wr_data_d  = rx_byte;
                cur_addr_d = addr_inc;
                state_d    = ST_WDATA_ACK;
              end
            end
          end
        end
        // First fall drives the 9th bit, the fall after the 9th rise ends it.
        ST_ID_ACK, ST_ADDR_ACK, ST_WDATA_ACK: begin
          if (ev_rise) begin
            bit9_d = 1'b1;
          end else if (ev_fall) begin
            if (!bit9_q) begin
              oe_d = ACK_DRIVE;
            end else begin
              oe_d      = 1'b0;
              bit9_d    = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ID_ACK && rnw_q) begin
                state_d = ST_RDATA;
                shift_d = rd_cur;
                oe_d    = ~rd_cur[7];
              end else if (state_q == ST_ID_ACK) begin
                state_d = ST_ADDR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (ev_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              bit9_d  = 1'b0;
              state_d = ST_RDATA_NA;
            end
          end else if (ev_fall) begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
          end
        end
        ST_RDATA_NA: begin
          if (ev_rise) begin
            bit9_d     = 1'b1;
            na_d       = sda;
            rd_valid_d = 1'b1;
          end else if (ev_fall) begin
            oe_d = 1'b0;
            if (bit9_q) begin
              bit9_d = 1'b0;
              if (na_q) begin
                state_d = ST_IGNORE;
              end else begin
                cur_addr_d = addr_inc;
                shift_d    = rd_nxt;
                oe_d       = ~rd_nxt[7];
                bit_cnt_d  = '0;
                state_d    = ST_RDATA;
              end
            end
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      cur_addr_q <= '0;
      oe_q       <= 1'b0;
      bit9_q     <= 1'b0;
      rnw_q      <= 1'b0;
      na_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      cur_addr_q <= cur_addr_d;
      oe_q       <= oe_d;
      bit9_q     <= bit9_d;
      rnw_q      <= rnw_d;
      na_q       <= na_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) reg_q[i] <= '0;
    end else if (reg_we) begin
      reg_q[cur_addr_q] <= rx_byte;
    end
  end

  assign siod_io   = oe_q ? 1'b0 : 1'bz;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign host_data = reg_q[host_addr];

endmodule

// File: tb/tb_sccb_responder.sv
// tb/tb_sccb_responder.sv - directed bench driving an SCCB master against sccb_responder
module tb_sccb_responder;

  localparam int QTR = 10;
`ifdef SCCB_RESP_ACK_EN
  localparam logic EXP_ACK = 1'b0;
`else
  localparam logic EXP_ACK = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_sioc = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] host_addr = 8'h00;
  wire        siod;
  logic       wr_valid, rd_valid, busy;
  logic [7:0] wr_addr, wr_data, host_data;

  int         n_chk = 0;
  int         n_fail = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         low_cnt = 0;
  logic [7:0] last_wa = 8'h00;
  logic [7:0] last_wd = 8'h00;

  pullup (siod);
  assign siod = m_sda ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  sccb_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sioc_i    (m_sioc),
    .siod_io   (siod),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .host_addr (host_addr),
    .host_data (host_data)
  );

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wr_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (rd_valid === 1'b1) rd_cnt++;
    if (siod === 1'b0 && m_sda) low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic qwait();
    repeat (QTR) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; qwait();
    m_sioc = 1'b1; qwait();
    m_sda = 1'b0; qwait();
    m_sioc = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; qwait();
    m_sioc = 1'b1; qwait();
    m_sda = 1'b1; qwait(); qwait();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b; qwait();
    m_sioc = 1'b1; qwait();
    s = siod; qwait();
    m_sioc = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(1'b1, d[i]);
    clk_bit(nack, s);
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    host_addr = a;
    #1;
    d = host_data;
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rd;
    logic [3:0] nib;
    int         w0, r0, l0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_siod", siod, 1'b1);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_host_data", host_data, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    qwait();

    // 3-phase write 42 / 12 / 80
    w0 = wr_cnt;
    bus_start();
    chk("a_busy_start", busy, 1'b1);
    write_byte(8'h42, ack); chk("a_id_ack", ack, EXP_ACK);
    write_byte(8'h12, ack); chk("a_addr_ack", ack, EXP_ACK);
    write_byte(8'h80, ack); chk("a_data_ack", ack, EXP_ACK);
    bus_stop();
    chk("a_wr_cnt", wr_cnt - w0, 1);
    chk("a_wr_addr", last_wa, 8'h12);
    chk("a_wr_data", last_wd, 8'h80);
    peek(8'h12, rd); chk("a_host_12", rd, 8'h80);
    chk("a_busy_stop", busy, 1'b0);

    // preload 0A = 76, then 2-phase address write and a single-byte read
    bus_start();
    write_byte(8'h42, ack); write_byte(8'h0A, ack); write_byte(8'h76, ack);
    bus_stop();
    w0 = wr_cnt; r0 = rd_cnt;
    bus_start();
    write_byte(8'h42, ack); write_byte(8'h0A, ack);
    bus_stop();
    chk("b_2ph_no_write", wr_cnt - w0, 0);
    bus_start();
    write_byte(8'h43, ack); chk("b_rd_id_ack", ack, EXP_ACK);
    read_byte(1'b1, rd);
    bus_stop();
    chk("b_rd_data", rd, 8'h76);
    chk("b_rd_cnt", rd_cnt - r0, 1);
    chk("b_no_wr", wr_cnt - w0, 0);

    // write burst across FF -> 00
    w0 = wr_cnt;
    bus_start();
    write_byte(8'h42, ack); write_byte(8'hFF, ack);
    write_byte(8'h11, ack); write_byte(8'h22, ack);
    bus_stop();
    chk("c_wr_cnt", wr_cnt - w0, 2);
    chk("c_last_wa", last_wa, 8'h00);
    peek(8'hFF, rd); chk("c_host_ff", rd, 8'h11);
    peek(8'h00, rd); chk("c_host_00", rd, 8'h22);

    // read burst across FF -> 00
    bus_start();
    write_byte(8'h42, ack); write_byte(8'hFF, ack);
    bus_stop();
    r0 = rd_cnt;
    bus_start();
    write_byte(8'h43, ack);
    read_byte(1'b0, rd); chk("c_rd_ff", rd, 8'h11);
    read_byte(1'b1, rd); chk("c_rd_00", rd, 8'h22);
    bus_stop();
    chk("c_rd_cnt", rd_cnt - r0, 2);

    // foreign device ID: responder must stay off the line
    w0 = wr_cnt; l0 = low_cnt;
    bus_start();
    write_byte(8'h60, ack); chk("d_id_ack", ack, 1'b1);
    write_byte(8'h12, ack); chk("d_addr_ack", ack, 1'b1);
    write_byte(8'h34, ack);
    chk("d_busy", busy, 1'b1);
    bus_stop();
    chk("d_busy_stop", busy, 1'b0);
    chk("d_no_drive", low_cnt - l0, 0);
    chk("d_no_wr", wr_cnt - w0, 0);
    peek(8'h12, rd); chk("d_host_12", rd, 8'h80);

    // reset while the responder is driving bit 3 of 76
    bus_start();
    write_byte(8'h42, ack); write_byte(8'h0A, ack);
    bus_stop();
    bus_start();
    write_byte(8'h43, ack);
    for (int i = 3; i >= 0; i--) clk_bit(1'b1, nib[i]);
    chk("e_nibble", nib, 4'h7);
    chk("e_drive_b3", siod, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("e_siod_release", siod, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("e_busy_rst", busy, 1'b0);
    peek(8'h0A, rd); chk("e_regfile_cleared", rd, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    qwait();
    bus_stop();
    w0 = wr_cnt;
    bus_start();
    write_byte(8'h42, ack); chk("e_id_ack", ack, EXP_ACK);
    write_byte(8'h33, ack);
    write_byte(8'h5A, ack); chk("e_data_ack", ack, EXP_ACK);
    bus_stop();
    chk("e_wr_cnt", wr_cnt - w0, 1);
    chk("e_wr_addr", last_wa, 8'h33);
    peek(8'h33, rd); chk("e_host_33", rd, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sccb_responder.md
# sccb_responder

SCCB responder that emulates the slave end of the camera register bus so the camera-setup master can be exercised without a sensor. It monitors SIOC/SIOD, matches the device ID, services 3-phase writes, 2-phase address writes and 2-phase reads against an internal 256×8 register file, and reports every committed write to the fabric. It sits on the same SIOC/SIOD pins the master drives, in bench tops and loopback FPGA builds.

## Interface
- DEV_ID, 8'h42: 7-bit device address in bits [7:1]; bit 0 ignored.
- clk  in  1  system clock; must be ≥ 20× SIOC frequency.
- rst_n  in  1  asynchronous, active-low reset.
- sioc_i  in  1  SCCB clock from master, asynchronous to clk.
- siod_io  inout  1  SCCB data; driven only to 0, otherwise high-Z (external pull-up).
- wr_valid  out  1  one-cycle pulse per committed write byte.
- wr_addr  out  8  register address of that write.
- wr_data  out  8  data of that write.
- rd_valid  out  1  one-cycle pulse when a read byte has been shifted out.
- busy  out  1  high from START detect until STOP detect.
- host_addr  in  8  fabric-side read address.
- host_data  out  8  reg_file[host_addr], combinational.

## Operation
- Both pins pass through a 2-flop synchronizer, then a registered previous-value compare gives rise/fall events for SIOC and SIOD.
- START = SIOD fall while SIOC high; STOP = SIOD rise while SIOC high. Both are honoured from every state: START → ID (repeated start allowed); STOP → IDLE.
- Bits are sampled on SIOC rise, MSB first; a 3-bit counter counts 8 bits per byte; SIOD output changes only on the SIOC fall event.
- States: IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE.
- ID: after 8 bits, if byte[7:1] ≠ DEV_ID[7:1] → IGNORE (never drives SIOD until STOP/START). Match with bit0 = 0 → ID_ACK → ADDR; bit0 = 1 → ID_ACK → RDATA, loading shift register with reg_file[cur_addr].
- ADDR: byte loads cur_addr → ADDR_ACK → WDATA. A STOP here is a 2-phase write: the address is kept and nothing is written.
- WDATA: byte writes reg_file[cur_addr]; wr_valid pulses with wr_addr = cur_addr. → WDATA_ACK; cur_addr += 1 (8-bit wrap, FF → 00) ready for a following byte.
- RDATA: drive SIOD low for each 0 bit, release for each 1 bit. → RDATA_NA: release SIOD, sample master bit and pulse rd_valid. Master 1 (NA) → wait for STOP. Master 0 → cur_addr += 1 (wrap), reload, RDATA.
- Reset: state IDLE, cur_addr 0, reg_file all 0, SIOD released, wr_valid/rd_valid/busy 0, wr_addr/wr_data 0. A reset mid-transaction releases SIOD immediately (async).
- A fabric host_addr read concurrent with an SCCB write returns the old value in the write cycle and the new value from the next cycle.

## Timing
- Line event latency: 3 clk after the pin edge.
- ACK/data drive asserted 1 clk after the SIOC fall event and held through the next SIOC fall event.
- wr_valid asserted 1 clk after the 8th-bit SIOC rise event of the data byte.
- busy rises 1 clk after the START event and falls 1 clk after the STOP event.

## Configuration
- SCCB_RESP_ACK_EN defined: drive SIOD low during the ID_ACK, ADDR_ACK and WDATA_ACK bits (I2C-style ACK, as OV7670 does).
- SCCB_RESP_ACK_EN undefined: release SIOD in those bits (pure SCCB don't-care). The master then sees 1; its ack-error retry path is exercised.

## Structure
- sccb_pkg holds:
  - the state enum;
  - SCCB_BITS = 8;
  - DEV_ID_DEFAULT = 8'h42;
  - REG_DEPTH = 256.
- Sub-module sccb_line_sync: synchronizers plus START/STOP/SIOC-rise/SIOC-fall event generation, instantiated once.

## Test plan
- 3-phase write ID 42, addr 12, data 80 → wr_valid once with wr_addr 12 / wr_data 80; host_addr 12 reads 80; ACK low (macro on).
- 2-phase write addr 0A, STOP, then read ID 43 → data byte 76 on SIOD after preload reg[0A] = 76; rd_valid once; no wr_valid.
- Write addr FF, data 11, 22 in one transaction → reg[FF] = 11, reg[00] = 22 (wrap).
- ID 60 write → SIOD never driven; no wr_valid; busy high until STOP.
- rst_n low during RDATA bit 3 → SIOD high-Z within 1 clk; state IDLE; next transaction completes normally.
- Macro off, write ID 42 addr 12 → SIOD high in every ACK bit; the register is still written.
